// File: rtl/axi4_lite_pkg.sv
// Shared types and constants for the AXI4-Lite crossbar: response codes,
// FSM state encodings and the default SRAM/device address map.
package axi4_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA, R_ERR} rd_state_t;
  typedef enum logic [1:0] {W_IDLE, W_REQ, W_RESP, W_ERR} wr_state_t;

  // Element 0 is the SRAM window, element 1 the UART/CLINT page.
  localparam logic [1:0][31:0] DEF_BASE = {32'ha000_0000, 32'h8000_0000};
  localparam logic [1:0][31:0] DEF_MASK = {32'hFFFF_F000, 32'hF800_0000};

endpackage

// File: rtl/axi4_lite_addr_decode.sv
// Combinational address decoder: finds the lowest-indexed slave whose
// (addr & MASK) matches BASE.
module axi4_lite_addr_decode #(
  parameter int unsigned               NSLV = 2,
  parameter int unsigned               IDXW = 1,
  parameter logic [NSLV-1:0][31:0]     BASE = '0,
  parameter logic [NSLV-1:0][31:0]     MASK = '0
) (
  input  logic [31:0]     addr_i,
  output logic            hit_o,
  output logic [IDXW-1:0] idx_o
);

  always_comb begin
    hit_o = 1'b0;
    idx_o = '0;
    for (int unsigned i = 0; i < NSLV; i++) begin
      if (!hit_o && ((addr_i & MASK[i]) == BASE[i])) begin
        hit_o = 1'b1;
        idx_o = IDXW'(i);
      end
    end
  end

endmodule

// File: rtl/axi4_lite_xbar.sv
// AXI4-Lite 1-to-N crossbar: independent read and write FSMs, one outstanding
// transaction per direction, local DECERR for unmapped addresses.
module axi4_lite_xbar
  import axi4_lite_pkg::*;
#(
  parameter int unsigned           NSLV = 2,
  parameter logic [NSLV-1:0][31:0] BASE = DEF_BASE,
  parameter logic [NSLV-1:0][31:0] MASK = DEF_MASK
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [31:0]                araddr,
  input  logic                       arvalid,
  output logic                       arready,
  output logic [31:0]                rdata,
  output logic [1:0]                 rresp,
  output logic                       rvalid,
  input  logic                       rready,
  input  logic [31:0]                awaddr,
  input  logic                       awvalid,
  output logic                       awready,
  input  logic [31:0]                wdata,
  input  logic [3:0]                 wstrb,
  input  logic                       wvalid,
  output logic                       wready,
  output logic [1:0]                 bresp,
  output logic                       bvalid,
  input  logic                       bready,
  output logic [NSLV-1:0][31:0]      saraddr,
  output logic [NSLV-1:0]            sarvalid,
  input  logic [NSLV-1:0]            sarready,
  input  logic [NSLV-1:0][31:0]      srdata,
  input  logic [NSLV-1:0][1:0]       srresp,
  input  logic [NSLV-1:0]            srvalid,
  output logic [NSLV-1:0]            srready,
  output logic [NSLV-1:0][31:0]      sawaddr,
  output logic [NSLV-1:0]            sawvalid,
  input  logic [NSLV-1:0]            sawready,
  output logic [NSLV-1:0][31:0]      swdata,
  output logic [NSLV-1:0][3:0]       swstrb,
  output logic [NSLV-1:0]            swvalid,
  input  logic [NSLV-1:0]            swready,
  input  logic [NSLV-1:0][1:0]       sbresp,
  input  logic [NSLV-1:0]            sbvalid,
  output logic [NSLV-1:0]            sbready
);

  localparam int unsigned IDXW = (NSLV > 1) ? $clog2(NSLV) : 1;

  rd_state_t       rd_state_q;
  logic [31:0]     araddr_q;
  logic [IDXW-1:0] rsel_q;
  wr_state_t       wr_state_q;
  logic [31:0]     awaddr_q, wdata_q;
  logic [3:0]      wstrb_q;
  logic [IDXW-1:0] wsel_q;
  logic            aw_got_q, w_got_q, aw_done_q, w_done_q;

  logic            rd_hit, wr_hit, aw_hs, w_hs;
  logic [IDXW-1:0] rd_idx, wr_idx;
  logic [31:0]     wr_dec_addr;

  axi4_lite_addr_decode #(.NSLV(NSLV), .IDXW(IDXW), .BASE(BASE), .MASK(MASK)) u_rd_dec (
    .addr_i(araddr), .hit_o(rd_hit), .idx_o(rd_idx)
  );

  // Decoding the live awaddr when AW arrives last lets the request go out
  // the very next cycle instead of waiting for the latch.
  assign wr_dec_addr = aw_got_q ? awaddr_q : awaddr;

  axi4_lite_addr_decode #(.NSLV(NSLV), .IDXW(IDXW), .BASE(BASE), .MASK(MASK)) u_wr_dec (
    .addr_i(wr_dec_addr), .hit_o(wr_hit), .idx_o(wr_idx)
  );

  assign aw_hs = awvalid && awready;
  assign w_hs  = wvalid && wready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_state_q <= R_IDLE;
      araddr_q   <= '0;
      rsel_q     <= '0;
    end else begin
      unique case (rd_state_q)
        R_IDLE: if (arvalid) begin
          araddr_q   <= araddr;
          rsel_q     <= rd_idx;
          rd_state_q <= rd_hit ? R_ADDR : R_ERR;
        end
        R_ADDR: if (sarready[rsel_q]) rd_state_q <= R_DATA;
        R_DATA: if (srvalid[rsel_q] && rready) rd_state_q <= R_IDLE;
        R_ERR:  if (rready) rd_state_q <= R_IDLE;
        default: rd_state_q <= R_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_state_q <= W_IDLE;
      awaddr_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      wsel_q     <= '0;
      aw_got_q   <= 1'b0;
      w_got_q    <= 1'b0;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
    end else begin
      unique case (wr_state_q)
        W_IDLE: begin
          if (aw_hs) begin
            awaddr_q <= awaddr;
            aw_got_q <= 1'b1;
          end
          if (w_hs) begin
            wdata_q <= wdata;
            wstrb_q <= wstrb;
            w_got_q <= 1'b1;
          end
          if ((aw_got_q || aw_hs) && (w_got_q || w_hs)) begin
            wsel_q     <= wr_idx;
            wr_state_q <= wr_hit ? W_REQ : W_ERR;
          end
        end
        W_REQ: begin
          if (sawready[wsel_q]) aw_done_q <= 1'b1;
          if (swready[wsel_q])  w_done_q  <= 1'b1;
          if ((aw_done_q || sawready[wsel_q]) && (w_done_q || swready[wsel_q]))
            wr_state_q <= W_RESP;
        end
        W_RESP, W_ERR: begin
          if (bready && (wr_state_q == W_ERR || sbvalid[wsel_q])) begin
            wr_state_q <= W_IDLE;
            aw_got_q   <= 1'b0;
            w_got_q    <= 1'b0;
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
          end
        end
        default: wr_state_q <= W_IDLE;
      endcase
    end
  end

  // Readies are gated by rst so they stay low throughout reset.
  always_comb begin
    arready  = rst && (rd_state_q == R_IDLE);
    awready  = rst && (wr_state_q == W_IDLE) && !aw_got_q;
    wready   = rst && (wr_state_q == W_IDLE) && !w_got_q;
    rvalid   = 1'b0;
    rdata    = '0;
    rresp    = '0;
    bvalid   = 1'b0;
    bresp    = '0;
    saraddr  = '0;
    sarvalid = '0;
    srready  = '0;
    sawaddr  = '0;
    sawvalid = '0;
    swdata   = '0;
    swstrb   = '0;
    swvalid  = '0;
    sbready  = '0;
    if (rd_state_q == R_DATA) begin
      rvalid = srvalid[rsel_q];
      rdata  = srdata[rsel_q];
      rresp  = srresp[rsel_q];
    end else if (rd_state_q == R_ERR) begin
      rvalid = 1'b1;
      rresp  = RESP_DECERR;
    end
    if (wr_state_q == W_RESP) begin
      bvalid = sbvalid[wsel_q];
      bresp  = sbresp[wsel_q];
    end else if (wr_state_q == W_ERR) begin
      bvalid = 1'b1;
      bresp  = RESP_DECERR;
    end
    for (int unsigned i = 0; i < NSLV; i++) begin
      if (rsel_q == IDXW'(i)) begin
        if (rd_state_q == R_ADDR) begin
          sarvalid[i] = 1'b1;
          saraddr[i]  = araddr_q;
        end
        if (rd_state_q == R_DATA) srready[i] = rready;
      end
      if (wsel_q == IDXW'(i)) begin
        if (wr_state_q == W_REQ) begin
          sawvalid[i] = !aw_done_q;
          swvalid[i]  = !w_done_q;
          sawaddr[i]  = awaddr_q;
          swdata[i]   = wdata_q;
          swstrb[i]   = wstrb_q;
        end
        if (wr_state_q == W_RESP) sbready[i] = bready;
      end
    end
  end

endmodule

// File: tb/tb_axi4_lite_xbar.sv
// Directed bench for axi4_lite_xbar: a vector table of single transactions
// plus hand-written sequences for backpressure, concurrency and reset.
module tb_axi4_lite_xbar;

  logic             clk = 1'b0;
  logic             rst;
  logic [31:0]      araddr, awaddr, wdata, rdata;
  logic             arvalid, arready, rvalid, rready;
  logic             awvalid, awready, wvalid, wready, bvalid, bready;
  logic [3:0]       wstrb;
  logic [1:0]       rresp, bresp;
  logic [1:0][31:0] saraddr, srdata, sawaddr, swdata;
  logic [1:0]       sarvalid, sarready, srvalid, srready;
  logic [1:0]       sawvalid, sawready, swvalid, swready, sbvalid, sbready;
  logic [1:0][1:0]  srresp, sbresp;
  logic [1:0][3:0]  swstrb;

  int n_cmp = 0;
  int n_bad = 0;
  int ar_cyc[2] = '{0, 0};
  int aw_cyc[2] = '{0, 0};

  always #5 clk = ~clk;

  axi4_lite_xbar #(.NSLV(2)) dut (
    .clk(clk), .rst(rst),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .saraddr(saraddr), .sarvalid(sarvalid), .sarready(sarready),
    .srdata(srdata), .srresp(srresp), .srvalid(srvalid), .srready(srready),
    .sawaddr(sawaddr), .sawvalid(sawvalid), .sawready(sawready),
    .swdata(swdata), .swstrb(swstrb), .swvalid(swvalid), .swready(swready),
    .sbresp(sbresp), .sbvalid(sbvalid), .sbready(sbready)
  );

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (sarvalid[i]) ar_cyc[i]++;
      if (sawvalid[i] || swvalid[i]) aw_cyc[i]++;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;   // write data, or slave read data
    logic [3:0]  strb;
    int          lead;   // >0: W leads AW by this many cycles; <0: AW leads
    int          slv;    // expected target slave, -1 for unmapped
    logic [1:0]  sresp;
    logic [31:0] exp_data;
    logic [1:0]  exp_resp;
  } vec_t;

  task automatic do_read(input string nm, input logic [31:0] addr, input int slv,
                         input logic [31:0] sdat, input logic [1:0] sresp,
                         input logic [31:0] exp_data, input logic [1:0] exp_resp);
    int a0[2];
    a0 = ar_cyc;
    araddr = addr; arvalid = 1'b1;
    #1;
    chk({nm, "_arready"}, 32'(arready), 32'd1);
    chk({nm, "_sarvalid_N"}, 32'(sarvalid), 32'd0);
    tick();
    arvalid = 1'b0;
    #1;
    if (slv >= 0) begin
      chk({nm, "_sarvalid_N1"}, 32'(sarvalid), 32'(1 << slv));
      chk({nm, "_saraddr"}, saraddr[slv], addr);
      sarready[slv] = 1'b1;
      tick();
      sarready = '0;
      srvalid[slv] = 1'b1; srdata[slv] = sdat; srresp[slv] = sresp; rready = 1'b1;
      #1;
      chk({nm, "_srready"}, 32'(srready), 32'(1 << slv));
    end else begin
      chk({nm, "_no_sarvalid"}, 32'(sarvalid), 32'd0);
      rready = 1'b1;
      #1;
    end
    chk({nm, "_rvalid"}, 32'(rvalid), 32'd1);
    chk({nm, "_rdata"}, rdata, exp_data);
    chk({nm, "_rresp"}, 32'(rresp), 32'(exp_resp));
    tick();
    srvalid = '0; srdata = '0; srresp = '0; rready = 1'b0;
    #1;
    chk({nm, "_rvalid_done"}, 32'(rvalid), 32'd0);
    chk({nm, "_arready_again"}, 32'(arready), 32'd1);
    for (int i = 0; i < 2; i++)
      if (i != slv) chk($sformatf("%s_ar_untouched%0d", nm, i), 32'(ar_cyc[i] - a0[i]), 32'd0);
  endtask

  task automatic do_write(input string nm, input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input int lead, input int slv,
                          input logic [1:0] sresp, input logic [1:0] exp_resp);
    int a0[2];
    int aw_at, w_at, c;
    bit awd, wd;
    a0 = aw_cyc;
    aw_at = (lead > 0) ? lead : 0;
    w_at  = (lead < 0) ? -lead : 0;
    awd = 1'b0; wd = 1'b0; c = 0;
    awaddr = addr; wdata = data; wstrb = strb;
    while (!(awd && wd) && c < 12) begin
      awvalid = !awd && (c >= aw_at);
      wvalid  = !wd && (c >= w_at);
      #1;
      if (awvalid && awready) awd = 1'b1;
      if (wvalid && wready) wd = 1'b1;
      chk({nm, "_no_early_req"}, 32'(sawvalid | swvalid), 32'd0);
      tick();
      c++;
    end
    awvalid = 1'b0; wvalid = 1'b0;
    #1;
    chk({nm, "_handshakes"}, 32'(awd && wd), 32'd1);
    if (slv >= 0) begin
      chk({nm, "_sawvalid"}, 32'(sawvalid), 32'(1 << slv));
      chk({nm, "_swvalid"}, 32'(swvalid), 32'(1 << slv));
      chk({nm, "_sawaddr"}, sawaddr[slv], addr);
      chk({nm, "_swdata"}, swdata[slv], data);
      chk({nm, "_swstrb"}, 32'(swstrb[slv]), 32'(strb));
      sawready[slv] = 1'b1; swready[slv] = 1'b1;
      tick();
      sawready = '0; swready = '0;
      sbvalid[slv] = 1'b1; sbresp[slv] = sresp; bready = 1'b1;
      #1;
      chk({nm, "_sbready"}, 32'(sbready), 32'(1 << slv));
    end else begin
      chk({nm, "_no_swvalid"}, 32'(sawvalid | swvalid), 32'd0);
      bready = 1'b1;
      #1;
    end
    chk({nm, "_bvalid"}, 32'(bvalid), 32'd1);
    chk({nm, "_bresp"}, 32'(bresp), 32'(exp_resp));
    tick();
    sbvalid = '0; sbresp = '0; bready = 1'b0;
    #1;
    chk({nm, "_bvalid_done"}, 32'(bvalid), 32'd0);
    chk({nm, "_ready_again"}, 32'(awready && wready), 32'd1);
    for (int i = 0; i < 2; i++)
      if (i != slv) chk($sformatf("%s_aw_untouched%0d", nm, i), 32'(aw_cyc[i] - a0[i]), 32'd0);
  endtask

  vec_t vecs[9];

  initial begin
    vecs[0] = '{1'b0, 32'h8000_0010, 32'hDEAD_BEEF, 4'h0,  0,  0, 2'b00, 32'hDEAD_BEEF, 2'b00};
    vecs[1] = '{1'b1, 32'ha000_03f8, 32'h0000_0041, 4'h1,  2,  1, 2'b00, 32'h0,         2'b00};
    vecs[2] = '{1'b0, 32'h0000_1000, 32'h0,         4'h0,  0, -1, 2'b00, 32'h0,         2'b11};
    vecs[3] = '{1'b1, 32'h9000_0000, 32'h1234_5678, 4'hF,  0, -1, 2'b00, 32'h0,         2'b11};
    vecs[4] = '{1'b0, 32'ha000_0ffc, 32'h1234_5678, 4'h0,  0,  1, 2'b10, 32'h1234_5678, 2'b10};
    vecs[5] = '{1'b0, 32'ha000_1000, 32'h0,         4'h0,  0, -1, 2'b00, 32'h0,         2'b11};
    vecs[6] = '{1'b1, 32'h87ff_fffc, 32'hCAFE_F00D, 4'hF,  0,  0, 2'b00, 32'h0,         2'b00};
    vecs[7] = '{1'b0, 32'h8800_0000, 32'h0,         4'h0,  0, -1, 2'b00, 32'h0,         2'b11};
    vecs[8] = '{1'b1, 32'h8000_0000, 32'h0BAD_CAFE, 4'h6, -3,  0, 2'b10, 32'h0,         2'b10};

    rst = 1'b0;
    araddr = '0; arvalid = 1'b0; rready = 1'b0;
    awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
    sarready = '0; srdata = '0; srresp = '0; srvalid = '0;
    sawready = '0; swready = '0; sbresp = '0; sbvalid = '0;

    tick();
    tick();
    chk("rst_readies", 32'({arready, awready, wready}), 32'd0);
    chk("rst_valids", 32'({rvalid, bvalid, sarvalid, sawvalid, swvalid}), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_resps", 32'({rresp, bresp}), 32'd0);
    rst = 1'b1;
    #1;
    chk("post_rst_readies", 32'({arready, awready, wready}), 32'h7);
    tick();

    for (int i = 0; i < 9; i++) begin
      if (vecs[i].wr)
        do_write($sformatf("v%0d", i), vecs[i].addr, vecs[i].data, vecs[i].strb,
                 vecs[i].lead, vecs[i].slv, vecs[i].sresp, vecs[i].exp_resp);
      else
        do_read($sformatf("v%0d", i), vecs[i].addr, vecs[i].slv, vecs[i].data,
                vecs[i].sresp, vecs[i].exp_data, vecs[i].exp_resp);
    end

    // rready held low for three cycles while slave 0 presents data
    araddr = 32'h8000_0020; arvalid = 1'b1;
    tick();
    arvalid = 1'b0;
    sarready[0] = 1'b1;
    tick();
    sarready = '0;
    srvalid[0] = 1'b1; srdata[0] = 32'h5A5A_0001; srresp[0] = 2'b00;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("bp%0d_srready", k), 32'(srready), 32'd0);
      chk($sformatf("bp%0d_rvalid", k), 32'(rvalid), 32'd1);
      chk($sformatf("bp%0d_rdata", k), rdata, 32'h5A5A_0001);
      chk($sformatf("bp%0d_arready", k), 32'(arready), 32'd0);
      tick();
    end
    rready = 1'b1;
    #1;
    chk("bp_srready", 32'(srready), 32'd1);
    tick();
    rready = 1'b0; srvalid = '0; srdata = '0;
    #1;
    chk("bp_single_hs", 32'(rvalid), 32'd0);
    chk("bp_arready", 32'(arready), 32'd1);
    tick();

    // read of slave 0 and write of slave 1 launched in the same cycle
    araddr = 32'h8000_0040; arvalid = 1'b1;
    awaddr = 32'ha000_0004; awvalid = 1'b1;
    wdata = 32'h7777_1111; wstrb = 4'hC; wvalid = 1'b1;
    tick();
    arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
    #1;
    chk("cc_sarvalid", 32'(sarvalid), 32'd1);
    chk("cc_sawvalid", 32'(sawvalid), 32'd2);
    chk("cc_swvalid", 32'(swvalid), 32'd2);
    chk("cc_swdata", swdata[1], 32'h7777_1111);
    sarready[0] = 1'b1; sawready[1] = 1'b1; swready[1] = 1'b1;
    tick();
    sarready = '0; sawready = '0; swready = '0;
    srvalid[0] = 1'b1; srdata[0] = 32'h0F0F_0F0F; sbvalid[1] = 1'b1; sbresp[1] = 2'b00;
    rready = 1'b1; bready = 1'b1;
    #1;
    chk("cc_rvalid", 32'(rvalid), 32'd1);
    chk("cc_rdata", rdata, 32'h0F0F_0F0F);
    chk("cc_bvalid", 32'(bvalid), 32'd1);
    chk("cc_bresp", 32'(bresp), 32'd0);
    tick();
    srvalid = '0; srdata = '0; sbvalid = '0; rready = 1'b0; bready = 1'b0;
    #1;
    chk("cc_idle", 32'({arready, awready, wready}), 32'h7);
    tick();

    // reset asserted while the read is waiting in R_ADDR
    araddr = 32'h8000_0080; arvalid = 1'b1;
    tick();
    arvalid = 1'b0;
    #1;
    chk("ra_sarvalid", 32'(sarvalid), 32'd1);
    rst = 1'b0;
    #1;
    chk("ra_sarvalid_drop", 32'(sarvalid), 32'd0);
    chk("ra_arready_low", 32'(arready), 32'd0);
    tick();
    chk("ra_arready_held", 32'(arready), 32'd0);
    rst = 1'b1;
    #1;
    chk("ra_arready_rel", 32'(arready), 32'd1);
    tick();
    do_read("ra_clean", 32'h8000_0084, 0, 32'h1357_9BDF, 2'b00, 32'h1357_9BDF, 2'b00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
